// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and scoreboard for a single-write-port register file.
//   alloc_*   : issue-time reservation of a destination register (sets busy)
//   s0_*/s1_* : ALU / LSU write-back sources, round-robin arbitrated
//   rf_*      : registered write port toward the register file (latency 1)
//   q1_*/q2_* : operand busy queries for RAW stall detection
//   busy_count: registered popcount of busy bits
//   err_unalloc: sticky flag, write-back hit a non-reserved nonzero register
module regfile_wb_scheduler #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic                  alloc_ready,
  input  logic                  s0_valid,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_data,
  output logic                  s1_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q1_addr,
  input  logic [ADDR_WIDTH-1:0] q2_addr,
  output logic                  q1_busy,
  output logic                  q2_busy,
  output logic [ADDR_WIDTH:0]   busy_count,
  output logic                  err_unalloc
);

  localparam int unsigned NREG = 2 ** ADDR_WIDTH;

  typedef enum logic {
    PRIO_S0 = 1'b0,
    PRIO_S1 = 1'b1
  } prio_t;

  prio_t                 prio_q, prio_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [ADDR_WIDTH:0]   busy_count_q, busy_count_d;
  logic                  err_q, err_d;

  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Arbitration and combinational handshake/query outputs
  always_comb begin
    s0_ready    = s0_valid & (~s1_valid | (prio_q == PRIO_S0));
    s1_ready    = s1_valid & (~s0_valid | (prio_q == PRIO_S1));
    wr_fire     = s0_ready | s1_ready;
    wr_addr     = s0_ready ? s0_addr : s1_addr;
    wr_data     = s0_ready ? s0_data : s1_data;
    alloc_ready = (alloc_addr == '0) | ~busy_q[alloc_addr];
    q1_busy     = busy_q[q1_addr];
    q2_busy     = busy_q[q2_addr];
  end

  always_comb begin
    prio_d = prio_q;
    if (s0_ready) begin
      prio_d = PRIO_S1;
    end else if (s1_ready) begin
      prio_d = PRIO_S0;
    end

    rf_wen_d   = wr_fire & (wr_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (wr_fire) begin
      rf_waddr_d = wr_addr;
      rf_wdata_d = wr_data;
    end

    // Clear first, then set: a fresh reservation wins over a stray write to the same register
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (alloc_valid & alloc_ready & (alloc_addr != '0)) begin
      busy_d[alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;

    busy_count_d = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      busy_count_d = busy_count_d + (ADDR_WIDTH + 1)'(busy_d[i]);
    end

    err_d = err_q | (wr_fire & (wr_addr != '0) & ~busy_q[wr_addr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q       <= PRIO_S0;
      busy_q       <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      busy_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      busy_q       <= busy_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      busy_count_q <= busy_count_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    rf_wen      = rf_wen_q;
    rf_waddr    = rf_waddr_q;
    rf_wdata    = rf_wdata_q;
    busy_count  = busy_count_q;
    err_unalloc = err_q;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_valid;
  logic [AW-1:0] alloc_addr;
  logic          alloc_ready;
  logic          s0_valid;
  logic [AW-1:0] s0_addr;
  logic [DW-1:0] s0_data;
  logic          s0_ready;
  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic [DW-1:0] s1_data;
  logic          s1_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] q1_addr;
  logic [AW-1:0] q2_addr;
  logic          q1_busy;
  logic          q2_busy;
  logic [AW:0]   busy_count;
  logic          err_unalloc;

  int checks = 0;
  int failures = 0;

  regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(s1_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .busy_count(busy_count), .err_unalloc(err_unalloc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_addr = '0;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    q1_addr = '0; q2_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, busy_count, err_unalloc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got wen=%b waddr=%0d wdata=%h cnt=%0d err=%b required all 0",
               rf_wen, rf_waddr, rf_wdata, busy_count, err_unalloc);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (q1_busy !== 1'b0 || q2_busy !== 1'b0 || alloc_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_queries got q1=%b q2=%b ar=%b required 0 0 1", q1_busy, q2_busy, alloc_ready);
    end
  endtask

  task automatic test_alloc_write();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 5; q1_addr = 5;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || q1_busy !== 1'b0) begin
      failures++;
      $display("FAIL aw_alloc got ar=%b q1=%b required 1 0", alloc_ready, q1_busy);
    end
    tick();
    alloc_valid = 1'b0;
    #1;
    checks++;
    if (q1_busy !== 1'b1 || busy_count !== 6'd1) begin
      failures++;
      $display("FAIL aw_busy got q1=%b cnt=%0d required 1 1", q1_busy, busy_count);
    end
    s0_valid = 1'b1; s0_addr = 5; s0_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (s0_ready !== 1'b1) begin
      failures++;
      $display("FAIL aw_s0_ready got %b required 1", s0_ready);
    end
    tick();
    s0_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || q1_busy !== 1'b1) begin
      failures++;
      $display("FAIL aw_write got wen=%b waddr=%0d wdata=%h q1=%b required 1 5 deadbeef 1",
               rf_wen, rf_waddr, rf_wdata, q1_busy);
    end
    tick();
    checks++;
    if (rf_wen !== 1'b0 || q1_busy !== 1'b0 || busy_count !== 6'd0 || err_unalloc !== 1'b0 ||
        rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL aw_done got wen=%b q1=%b cnt=%0d err=%b waddr=%0d wdata=%h required 0 0 0 0 5 deadbeef",
               rf_wen, q1_busy, busy_count, err_unalloc, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a0 [5];
    logic [AW-1:0] a1 [5];
    logic          v1 [5];
    logic          r0 [5];
    logic [AW-1:0] wa [5];
    a0 = '{5'd1, 5'd3, 5'd3, 5'd0, 5'd0};
    a1 = '{5'd2, 5'd2, 5'd4, 5'd4, 5'd0};
    v1 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    r0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wa = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      alloc_valid = 1'b1; alloc_addr = AW'(i);
      tick();
    end
    alloc_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s0_valid = 1'b1; s0_addr = a0[c]; s0_data = 32'h100 + 32'(a0[c]);
      s1_valid = v1[c]; s1_addr = a1[c]; s1_data = 32'h200 + 32'(a1[c]);
      #1;
      checks++;
      if (s0_ready !== r0[c] || s1_ready !== (v1[c] & ~r0[c])) begin
        failures++;
        $display("FAIL rr_grant c=%0d got r0=%b r1=%b required %b %b",
                 c, s0_ready, s1_ready, r0[c], v1[c] & ~r0[c]);
      end
      tick();
      checks++;
      if (c < 4 && (rf_wen !== 1'b1 || rf_waddr !== wa[c])) begin
        failures++;
        $display("FAIL rr_write c=%0d got wen=%b waddr=%0d required 1 %0d", c, rf_wen, rf_waddr, wa[c]);
      end else if (c == 4 && rf_wen !== 1'b0) begin
        failures++;
        $display("FAIL rr_x0 got wen=%b required 0", rf_wen);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (busy_count !== 6'd0 || err_unalloc !== 1'b0) begin
      failures++;
      $display("FAIL rr_end got cnt=%0d err=%b required 0 0", busy_count, err_unalloc);
    end
  endtask

  task automatic test_waw();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 7;
    tick();
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_second got ar=%b required 0", alloc_ready);
    end
    tick();
    alloc_addr = 0; q1_addr = 0;
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || q1_busy !== 1'b0) begin
      failures++;
      $display("FAIL waw_x0 got ar=%b q1=%b required 1 0", alloc_ready, q1_busy);
    end
    tick();
    alloc_addr = 9; q2_addr = 9;
    #1;
    checks++;
    if (busy_count !== 6'd1 || q2_busy !== 1'b0) begin
      failures++;
      $display("FAIL waw_same_cycle got cnt=%0d q2=%b required 1 0", busy_count, q2_busy);
    end
    tick();
    alloc_valid = 1'b0;
    s0_valid = 1'b1; s0_addr = 7; s0_data = 32'h77;
    #1;
    checks++;
    if (q2_busy !== 1'b1 || busy_count !== 6'd2) begin
      failures++;
      $display("FAIL waw_after got q2=%b cnt=%0d required 1 2", q2_busy, busy_count);
    end
    tick();
    s0_valid = 1'b0;
    alloc_valid = 1'b1; alloc_addr = 7;
    #1;
    checks++;
    if (rf_wen !== 1'b1 || alloc_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_no_bypass got wen=%b ar=%b required 1 0", rf_wen, alloc_ready);
    end
    tick();
    #1;
    checks++;
    if (alloc_ready !== 1'b1 || busy_count !== 6'd1) begin
      failures++;
      $display("FAIL waw_freed got ar=%b cnt=%0d required 1 1", alloc_ready, busy_count);
    end
    idle_inputs();
  endtask

  task automatic test_x0_write();
    do_reset();
    s1_valid = 1'b1; s1_addr = 0; s1_data = 32'h1234;
    #1;
    checks++;
    if (s1_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_ready got %b required 1", s1_ready);
    end
    tick();
    s1_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b0 || err_unalloc !== 1'b0) begin
      failures++;
      $display("FAIL x0_write got wen=%b err=%b required 0 0", rf_wen, err_unalloc);
    end
  endtask

  task automatic test_unalloc_err();
    do_reset();
    s0_valid = 1'b1; s0_addr = 9; s0_data = 32'hCAFE0009;
    tick();
    s0_valid = 1'b0;
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hCAFE0009 || err_unalloc !== 1'b1) begin
      failures++;
      $display("FAIL unalloc_set got wen=%b waddr=%0d wdata=%h err=%b required 1 9 cafe0009 1",
               rf_wen, rf_waddr, rf_wdata, err_unalloc);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (err_unalloc !== 1'b1 || busy_count !== 6'd0) begin
      failures++;
      $display("FAIL unalloc_sticky got err=%b cnt=%0d required 1 0", err_unalloc, busy_count);
    end
    do_reset();
    checks++;
    if (err_unalloc !== 1'b0) begin
      failures++;
      $display("FAIL unalloc_clear got err=%b required 0", err_unalloc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 1'b1; alloc_addr = 3;
    tick();
    alloc_valid = 1'b0;
    s0_valid = 1'b1; s0_addr = 3; s0_data = 32'h33; q1_addr = 3;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata, busy_count, err_unalloc, q1_busy} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs got wen=%b waddr=%0d wdata=%h cnt=%0d err=%b q1=%b required all 0",
               rf_wen, rf_waddr, rf_wdata, busy_count, err_unalloc, q1_busy);
    end
    tick();
    s0_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (rf_wen !== 1'b0 || busy_count !== 6'd0) begin
        failures++;
        $display("FAIL rstmid_after i=%0d got wen=%b cnt=%0d required 0 0", i, rf_wen, busy_count);
      end
    end
  endtask

  task automatic test_random();
    bit            m_busy [32];
    bit            nb [32];
    int            m_pri;
    bit            m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_err;
    bit            hold0, hold1;
    bit            e_ar, e_g0, e_g1;
    logic [AW-1:0] ga;
    int            cnt;
    do_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_pri = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
    hold0 = 1'b0; hold1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alloc_valid = ($urandom_range(0, 1) == 1);
      alloc_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      if (!hold0) begin
        s0_valid = ($urandom_range(0, 2) != 0);
        s0_addr  = AW'($urandom_range(0, 9));
        s0_data  = $urandom;
      end
      if (!hold1) begin
        s1_valid = ($urandom_range(0, 2) != 0);
        s1_addr  = AW'($urandom_range(0, 9));
        s1_data  = $urandom;
      end
      q1_addr = AW'($urandom_range(0, 9));
      q2_addr = AW'($urandom);
      #1;
      e_ar = (alloc_addr == 0) || !m_busy[alloc_addr];
      e_g0 = s0_valid && (!s1_valid || m_pri == 0);
      e_g1 = s1_valid && (!s0_valid || m_pri == 1);
      checks++;
      if (alloc_ready !== e_ar || s0_ready !== e_g0 || s1_ready !== e_g1) begin
        failures++;
        $display("FAIL rand_handshake cyc=%0d got ar=%b r0=%b r1=%b required %b %b %b",
                 cyc, alloc_ready, s0_ready, s1_ready, e_ar, e_g0, e_g1);
      end
      checks++;
      if (q1_busy !== m_busy[q1_addr] || q2_busy !== m_busy[q2_addr]) begin
        failures++;
        $display("FAIL rand_query cyc=%0d got q1=%b q2=%b required %b %b",
                 cyc, q1_busy, q2_busy, m_busy[q1_addr], m_busy[q2_addr]);
      end
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (alloc_valid && e_ar && alloc_addr != 0) nb[alloc_addr] = 1'b1;
      if (e_g0 || e_g1) begin
        ga = e_g0 ? s0_addr : s1_addr;
        if (ga != 0 && !m_busy[ga]) m_err = 1'b1;
        m_wen   = (ga != 0);
        m_waddr = ga;
        m_wdata = e_g0 ? s0_data : s1_data;
        m_pri   = e_g0 ? 1 : 0;
      end else begin
        m_wen = 1'b0;
      end
      m_busy = nb;
      cnt = 0;
      foreach (m_busy[i]) cnt += int'(m_busy[i]);
      hold0 = s0_valid && !e_g0;
      hold1 = s1_valid && !e_g1;
      tick();
      checks++;
      if (rf_wen !== m_wen || (m_wen && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
        failures++;
        $display("FAIL rand_write cyc=%0d got wen=%b waddr=%0d wdata=%h required %b %0d %h",
                 cyc, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
      end
      checks++;
      if (busy_count !== (AW + 1)'(cnt) || err_unalloc !== m_err) begin
        failures++;
        $display("FAIL rand_state cyc=%0d got cnt=%0d err=%b required %0d %b",
                 cyc, busy_count, err_unalloc, cnt, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alloc_write();
    test_back_to_back();
    test_waw();
    test_x0_write();
    test_unalloc_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
